alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle 16-bit ALU.
- Keeps the existing func4 encoding 0000–1000, with results now registered.
- Adds SLTU, SRA and an iterative multiply/divide unit: MUL, MULHU, DIVU, REMU.
- Sits between decode/operand-read and writeback; the core stalls on ready_o.

Parameters:
- WIDTH, 16: datapath width in bits, >= 4.
- SHW, $clog2(WIDTH): number of shift-amount bits taken from operand B (derived; do not override).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- func4  in  4  operation select.
- rs1_data_i  in  WIDTH  operand A.
- rs2_data_i  in  WIDTH  operand B, used when imm_en_i=0.
- imm_data_i  in  WIDTH  operand B, used when imm_en_i=1.
- imm_en_i  in  1  selects the immediate as B.
- jalr_en_i  in  1  with ADD: force result bit 0 to 0.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- alu_data_o  out  WIDTH  result.
- illegal_o  out  1  func4 unsupported; qualified by valid_o.

Behaviour:
- Operand capture:
  - A request is accepted on a rising edge with valid_i && ready_o.
  - A, B = (imm_en_i ? imm_data_i : rs2_data_i), func4 and jalr_en_i are captured on that edge.
  - All inputs are ignored otherwise.
- State machine: IDLE, BUSY, DONE.
  - ready_o = (state==IDLE). There is no accept in the same cycle as DONE, so there is no bypass.
  - IDLE, accept of a single-cycle op or illegal func4: result registered, go to DONE. valid_o is high in the cycle after the accept edge (latency 1).
  - IDLE, accept of MUL/MULHU/DIVU/REMU with nonzero divisor: load shift/accumulate registers, set count=WIDTH, go to BUSY.
  - BUSY: one radix-2 step per cycle, count decrements. After the WIDTH-th step, go to DONE. valid_o first high WIDTH+1 cycles after the accept edge.
  - DONE: hold alu_data_o and illegal_o stable. On valid_o && ready_i, go to IDLE. ready_i while not DONE is ignored.
- Op encoding. All arithmetic is modulo 2^WIDTH. Shifts use B[SHW-1:0] only.
  - 0000 ADD: A+B. If jalr_en_i, bit 0 is cleared.
  - 0001 SUB: A-B.
  - 0010 INV: ~A.
  - 0011 SLL: A<<B.
  - 0100 SRL: A>>B, logical.
  - 0101 AND, 0110 OR, 0111 XOR.
  - 1000 SLT: signed A<B gives 1, else 0.
  - 1001 SLTU: unsigned compare.
  - 1010 SRA: arithmetic right shift.
  - 1011 MUL: low WIDTH bits of A*B, unsigned.
  - 1100 MULHU: high WIDTH bits of the unsigned 2*WIDTH product.
  - 1101 DIVU: unsigned quotient.
  - 1110 REMU: unsigned remainder.
  - 1111: illegal. alu_data_o=0, illegal_o=1, latency 1.
  - illegal_o=0 for every other op.
- Divide by zero (B==0):
  - DIVU returns all-ones; REMU returns A.
  - No BUSY phase; latency 1.
- Reset (rst_i high at an edge):
  - state=IDLE, valid_o=0, alu_data_o=0, illegal_o=0, count=0.
  - ready_o is high in the following cycle.
  - Reset mid-BUSY or in DONE discards the operation; no result is produced.
- Simultaneous events:
  - rst_i dominates valid_i and ready_i.
  - valid_i while BUSY/DONE is not accepted; the requester must hold the request.
- Invariant: captured operands are unaffected by input changes after the accept edge.

Test Plan:
- Legacy ops, WIDTH=16, ready_i=1:
  - ADD 10+5 gives 15; ADDI 3 with imm 2 and rs2=999 gives 5.
  - SUB 5-4 gives 1; INV 2 gives 0xFFFD.
  - SLL 1<<4 gives 16; SRL 16>>4 gives 1.
  - AND 12&10 gives 8; OR 12|10 gives 14; XOR 12^10 gives 6; SLT 3<5 gives 1.
  - Each has valid_o exactly 1 cycle after accept and ready_o low for exactly 1 cycle.
- Signed vs unsigned, shift masking:
  - SLT 0xFFFF<1 gives 1; SLTU 0xFFFF<1 gives 0.
  - SRA 0x8000 by 3 gives 0xF000.
  - SLL 1 by rs2=0x0011 gives 2 (only the low 4 bits are used).
  - ADD with jalr_en_i, 0x1001+0x0002, gives 0x1002.
- Iterative ops:
  - MUL 300*300 gives 0x5F90; MULHU 300*300 gives 0x0001.
  - DIVU 100/7 gives 14; REMU 100/7 gives 2.
  - Each has valid_o exactly 17 cycles after accept and ready_o low throughout.
- Divide by zero:
  - DIVU 1234/0 gives 0xFFFF; REMU 1234/0 gives 1234.
  - Both with latency 1.
- Backpressure:
  - MUL 7*6 with ready_i=0 for 5 cycles after valid_o rises: alu_data_o holds 42, valid_o stays high, new valid_i is refused.
  - On ready_i=1, the unit returns to IDLE the next cycle.
- Reset and illegal:
  - rst_i asserted 5 cycles into a DIVU: the next cycle has valid_o=0, alu_data_o=0, ready_o=1, and no result ever appears.
  - func4=1111 gives illegal_o=1 and alu_data_o=0 at latency 1.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/result bundle between operand-read, the sequential ALU and writeback.
// Requester drives the operands and valid_i; the ALU answers with ready_o and the result side.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             valid_i;
   logic             ready_o;
   logic [3:0]       func4;
   logic [WIDTH-1:0] rs1_data_i;
   logic [WIDTH-1:0] rs2_data_i;
   logic [WIDTH-1:0] imm_data_i;
   logic             imm_en_i;
   logic             jalr_en_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] alu_data_o;
   logic             illegal_o;

   modport master (
      output valid_i, func4, rs1_data_i, rs2_data_i, imm_data_i, imm_en_i, jalr_en_i, ready_i,
      input  ready_o, valid_o, alu_data_o, illegal_o
   );

   modport slave (
      input  valid_i, func4, rs1_data_i, rs2_data_i, imm_data_i, imm_en_i, jalr_en_i, ready_i,
      output ready_o, valid_o, alu_data_o, illegal_o
   );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops latency 1, iterative MUL/MULHU/DIVU/REMU latency WIDTH+1.
// Accepts only when idle; the result is held in DONE until ready_i, so no request overlaps.
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic      clk_i,
   input logic      rst_i,
   alu_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_INV   = 4'b0010;
   localparam logic [3:0] OP_SLL   = 4'b0011;
   localparam logic [3:0] OP_SRL   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_OR    = 4'b0110;
   localparam logic [3:0] OP_XOR   = 4'b0111;
   localparam logic [3:0] OP_SLT   = 4'b1000;
   localparam logic [3:0] OP_SLTU  = 4'b1001;
   localparam logic [3:0] OP_SRA   = 4'b1010;
   localparam logic [3:0] OP_MUL   = 4'b1011;
   localparam logic [3:0] OP_MULHU = 4'b1100;
   localparam logic [3:0] OP_DIVU  = 4'b1101;
   localparam logic [3:0] OP_REMU  = 4'b1110;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] b_in, fast_res, iter_res, hi_n, lo_n;
   logic [WIDTH-1:0] hi_q, lo_q, b_q, alu_data_q;
   logic [SHW-1:0]   sh;
   logic [3:0]       op_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH:0]   sum, shifted, diff;
   logic             fast_ill, iterative, illegal_q, is_div, ge;

   // Decode of the request currently on the inputs; only meaningful while idle.
   always_comb begin
      b_in      = bus.imm_en_i ? bus.imm_data_i : bus.rs2_data_i;
      sh        = b_in[SHW-1:0];
      fast_res  = '0;
      fast_ill  = 1'b0;
      iterative = 1'b0;
      case (bus.func4)
         OP_ADD: begin
            fast_res = bus.rs1_data_i + b_in;
            if (bus.jalr_en_i) fast_res[0] = 1'b0;
         end
         OP_SUB:  fast_res = bus.rs1_data_i - b_in;
         OP_INV:  fast_res = ~bus.rs1_data_i;
         OP_SLL:  fast_res = bus.rs1_data_i << sh;
         OP_SRL:  fast_res = bus.rs1_data_i >> sh;
         OP_AND:  fast_res = bus.rs1_data_i & b_in;
         OP_OR:   fast_res = bus.rs1_data_i | b_in;
         OP_XOR:  fast_res = bus.rs1_data_i ^ b_in;
         OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(bus.rs1_data_i) < $signed(b_in))};
         OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (bus.rs1_data_i < b_in)};
         OP_SRA:  fast_res = $signed(bus.rs1_data_i) >>> sh;
         OP_MUL, OP_MULHU: iterative = 1'b1;
         OP_DIVU: begin
            if (b_in == '0) fast_res = '1;
            else            iterative = 1'b1;
         end
         OP_REMU: begin
            if (b_in == '0) fast_res = bus.rs1_data_i;
            else            iterative = 1'b1;
         end
         default: fast_ill = 1'b1;
      endcase
   end

   // Radix-2 step. Multiply: hi accumulates, lo holds the multiplier and collects product bits.
   // Divide (restoring): hi is the partial remainder, lo shifts dividend out and quotient in.
   always_comb begin
      is_div   = (op_q == OP_DIVU) || (op_q == OP_REMU);
      sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      shifted  = {hi_q, lo_q[WIDTH-1]};
      diff     = shifted - {1'b0, b_q};
      ge       = ~diff[WIDTH];
      if (is_div) begin
         hi_n = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         lo_n = {lo_q[WIDTH-2:0], ge};
      end else begin
         hi_n = sum[WIDTH:1];
         lo_n = {sum[0], lo_q[WIDTH-1:1]};
      end
      iter_res = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? hi_n : lo_n;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      bus.ready_o = (state_q == IDLE);
      bus.valid_o = (state_q == DONE);
      case (state_q)
         IDLE:    if (bus.valid_i) state_d = iterative ? BUSY : DONE;
         BUSY:    if (count_q == CW'(1)) state_d = DONE;
         DONE:    if (bus.ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         alu_data_q <= '0;
         illegal_q  <= 1'b0;
         count_q    <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         b_q        <= '0;
         op_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.valid_i) begin
                  op_q <= bus.func4;
                  b_q  <= b_in;
                  if (iterative) begin
                     hi_q      <= '0;
                     lo_q      <= bus.rs1_data_i;
                     count_q   <= CW'(WIDTH);
                     illegal_q <= 1'b0;
                  end else begin
                     alu_data_q <= fast_res;
                     illegal_q  <= fast_ill;
                  end
               end
            end
            BUSY: begin
               hi_q    <= hi_n;
               lo_q    <= lo_n;
               count_q <= count_q - CW'(1);
               if (count_q == CW'(1)) alu_data_q <= iter_res;
            end
            default: ;
         endcase
      end
   end

   assign bus.alu_data_o = alu_data_q;
   assign bus.illegal_o  = illegal_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=16: results, latency, backpressure, reset and illegal ops.
module tb_alu_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   alu_seq_if #(.WIDTH(16)) bus ();

   alu_seq #(.WIDTH(16)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one edge, then scramble every input to prove operands were captured.
   task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic imm_en, input logic jalr);
      bus.valid_i    = 1'b1;
      bus.func4      = f;
      bus.rs1_data_i = a;
      bus.rs2_data_i = b;
      bus.imm_data_i = imm;
      bus.imm_en_i   = imm_en;
      bus.jalr_en_i  = jalr;
      step();
      bus.valid_i    = 1'b0;
      bus.func4      = 4'hF;
      bus.rs1_data_i = 16'hA5A5;
      bus.rs2_data_i = 16'h5A5A;
      bus.imm_data_i = 16'h0F0F;
      bus.imm_en_i   = ~imm_en;
      bus.jalr_en_i  = 1'b1;
   endtask

   // Called right after issue(): cycle 1 is the sample just after the accept edge.
   task automatic wait_valid(input string tag, input int exp_lat);
      int lat     = 1;
      int rdy_hi  = 0;
      while (!bus.valid_o && lat < 40) begin
         if (bus.ready_o) rdy_hi++;
         step();
         lat++;
      end
      if (bus.ready_o) rdy_hi++;
      chk({tag, ".latency"}, lat, exp_lat);
      chk({tag, ".ready_low"}, rdy_hi, 0);
   endtask

   task automatic run_op(input string tag, input logic [3:0] f, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] imm, input logic imm_en,
                         input logic jalr, input logic [15:0] exp_d, input logic exp_ill,
                         input int exp_lat);
      bus.ready_i = 1'b1;
      chk({tag, ".ready_before"}, bus.ready_o, 1);
      issue(f, a, b, imm, imm_en, jalr);
      wait_valid(tag, exp_lat);
      chk({tag, ".data"}, bus.alu_data_o, exp_d);
      chk({tag, ".illegal"}, bus.illegal_o, exp_ill);
      step();
      chk({tag, ".idle_after"}, {bus.ready_o, bus.valid_o}, 2'b10);
   endtask

   initial begin
      bus.valid_i    = 1'b0;
      bus.ready_i    = 1'b1;
      bus.func4      = 4'h0;
      bus.rs1_data_i = '0;
      bus.rs2_data_i = '0;
      bus.imm_data_i = '0;
      bus.imm_en_i   = 1'b0;
      bus.jalr_en_i  = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("reset.ready", bus.ready_o, 1);
      chk("reset.valid", bus.valid_o, 0);
      chk("reset.data", bus.alu_data_o, 0);
      chk("reset.illegal", bus.illegal_o, 0);

      // Legacy ops
      run_op("add",  4'b0000, 16'd10, 16'd5,   16'd0, 1'b0, 1'b0, 16'd15, 1'b0, 1);
      run_op("addi", 4'b0000, 16'd3,  16'd999, 16'd2, 1'b1, 1'b0, 16'd5,  1'b0, 1);
      run_op("sub",  4'b0001, 16'd5,  16'd4,   16'd0, 1'b0, 1'b0, 16'd1,  1'b0, 1);
      run_op("inv",  4'b0010, 16'd2,  16'd0,   16'd0, 1'b0, 1'b0, 16'hFFFD, 1'b0, 1);
      run_op("sll",  4'b0011, 16'd1,  16'd4,   16'd0, 1'b0, 1'b0, 16'd16, 1'b0, 1);
      run_op("srl",  4'b0100, 16'd16, 16'd4,   16'd0, 1'b0, 1'b0, 16'd1,  1'b0, 1);
      run_op("and",  4'b0101, 16'd12, 16'd10,  16'd0, 1'b0, 1'b0, 16'd8,  1'b0, 1);
      run_op("or",   4'b0110, 16'd12, 16'd10,  16'd0, 1'b0, 1'b0, 16'd14, 1'b0, 1);
      run_op("xor",  4'b0111, 16'd12, 16'd10,  16'd0, 1'b0, 1'b0, 16'd6,  1'b0, 1);
      run_op("slt",  4'b1000, 16'd3,  16'd5,   16'd0, 1'b0, 1'b0, 16'd1,  1'b0, 1);

      // Signedness, shift-amount masking, jalr
      run_op("slt_neg",  4'b1000, 16'hFFFF, 16'd1,    16'd0, 1'b0, 1'b0, 16'd1,    1'b0, 1);
      run_op("sltu_big", 4'b1001, 16'hFFFF, 16'd1,    16'd0, 1'b0, 1'b0, 16'd0,    1'b0, 1);
      run_op("sra",      4'b1010, 16'h8000, 16'd3,    16'd0, 1'b0, 1'b0, 16'hF000, 1'b0, 1);
      run_op("sll_mask", 4'b0011, 16'd1,    16'h0011, 16'd0, 1'b0, 1'b0, 16'd2,    1'b0, 1);
      run_op("add_jalr", 4'b0000, 16'h1001, 16'h0002, 16'd0, 1'b0, 1'b1, 16'h1002, 1'b0, 1);

      // Iterative ops
      run_op("mul",   4'b1011, 16'd300, 16'd300, 16'd0, 1'b0, 1'b0, 16'h5F90, 1'b0, 17);
      run_op("mulhu", 4'b1100, 16'd300, 16'd300, 16'd0, 1'b0, 1'b0, 16'h0001, 1'b0, 17);
      run_op("divu",  4'b1101, 16'd100, 16'd7,   16'd0, 1'b0, 1'b0, 16'd14,   1'b0, 17);
      run_op("remu",  4'b1110, 16'd100, 16'd7,   16'd0, 1'b0, 1'b0, 16'd2,    1'b0, 17);
      run_op("mulhu_max", 4'b1100, 16'hFFFF, 16'hFFFF, 16'd0, 1'b0, 1'b0, 16'hFFFE, 1'b0, 17);
      run_op("divu_imm",  4'b1101, 16'hFFFF, 16'd0, 16'd16, 1'b1, 1'b0, 16'h0FFF, 1'b0, 17);

      // Divide by zero
      run_op("divu_zero", 4'b1101, 16'd1234, 16'd0, 16'd0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1);
      run_op("remu_zero", 4'b1110, 16'd1234, 16'd0, 16'd0, 1'b0, 1'b0, 16'd1234, 1'b0, 1);

      // Illegal
      run_op("illegal", 4'b1111, 16'd77, 16'd88, 16'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1);

      // Backpressure: result held while ready_i low, competing request refused
      bus.ready_i = 1'b0;
      issue(4'b1011, 16'd7, 16'd6, 16'd0, 1'b0, 1'b0);
      wait_valid("bp_mul", 17);
      bus.valid_i    = 1'b1;
      bus.func4      = 4'b0000;
      bus.rs1_data_i = 16'd1;
      bus.rs2_data_i = 16'd1;
      bus.imm_en_i   = 1'b0;
      bus.jalr_en_i  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp.hold_data", bus.alu_data_o, 16'd42);
         chk("bp.hold_state", {bus.valid_o, bus.ready_o}, 2'b10);
         step();
      end
      chk("bp.hold_final", {bus.valid_o, bus.alu_data_o}, {1'b1, 16'd42});
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      step();
      chk("bp.release", {bus.ready_o, bus.valid_o}, 2'b10);
      run_op("after_bp", 4'b0000, 16'd1, 16'd1, 16'd0, 1'b0, 1'b0, 16'd2, 1'b0, 1);

      // Reset during BUSY discards the divide
      issue(4'b1101, 16'd1000, 16'd7, 16'd0, 1'b0, 1'b0);
      repeat (4) step();
      chk("rst.busy_before", {bus.ready_o, bus.valid_o}, 2'b00);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst.valid", bus.valid_o, 0);
      chk("rst.data", bus.alu_data_o, 0);
      chk("rst.ready", bus.ready_o, 1);
      begin
         int seen = 0;
         for (int i = 0; i < 25; i++) begin
            if (bus.valid_o) seen++;
            step();
         end
         chk("rst.no_result", seen, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
